// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads one word per cycle from a
// combinational instruction memory and queues {pc, word} pairs for decode.
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       fetch_en,
   output logic [31:0]                imem_addr,
   input  logic [31:0]                imem_data,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_pc,
   output logic                       inst_valid,
   input  logic                       inst_ready,
   output logic [31:0]                inst_data,
   output logic [31:0]                inst_pc,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH-1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   fifo_pc   [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          pop;
   logic          push;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == LAST_PTR) return '0;
      return p + PW'(1);
   endfunction

   assign pop  = inst_valid & inst_ready;
   // A full FIFO can still accept a word when the head leaves in the same cycle.
   assign push = fetch_en & ~redirect_valid & ((count < DEPTH_C) | pop);

   assign imem_addr  = fetch_pc;
   assign inst_valid = (count != '0);
   assign inst_data  = inst_valid ? fifo_data[rd_ptr] : 32'h0;
   assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : 32'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (redirect_valid) begin
         // Flush wins over any concurrent pop; the pop still completes for decode.
         fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
            wr_ptr   <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]   <= fetch_pc;
         fifo_data[wr_ptr] <= imem_data;
      end
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: a reference queue tracks every fetched
// {pc, word}; DUT head, occupancy and fetch address are compared every cycle.
module tb_if_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_en = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [1:0]  count;

   logic [31:0] mem_xor = 32'h0;
   logic [31:0] m_pc;
   logic [63:0] sb[$];
   int          n_vec = 0;
   int          n_err = 0;

   assign imem_data = imem_addr ^ mem_xor;

   always #5 clk = ~clk;

   if_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_pc(inst_pc), .count(count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".count"}, 32'(count), 32'(sb.size()));
      check({tag, ".valid"}, 32'(inst_valid), 32'(sb.size() != 0));
      check({tag, ".addr"}, imem_addr, m_pc);
      if (sb.size() != 0) begin
         check({tag, ".pc"}, inst_pc, sb[0][63:32]);
         check({tag, ".data"}, inst_data, sb[0][31:0]);
      end else begin
         check({tag, ".pc0"}, inst_pc, 32'h0);
         check({tag, ".data0"}, inst_data, 32'h0);
      end
   endtask

   // One clock: advance the reference model with the applied inputs, then compare.
   task automatic step(input string tag);
      bit pop, push;
      pop = (sb.size() != 0) && inst_ready;
      push = fetch_en && !redirect_valid && ((sb.size() < DEPTH) || pop);
      @(posedge clk);
      if (redirect_valid) begin
         sb.delete();
         m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
         if (pop) void'(sb.pop_front());
         if (push) begin
            sb.push_back({m_pc, m_pc ^ mem_xor});
            m_pc = m_pc + 32'd4;
         end
      end
      #1;
      check_state(tag);
   endtask

   task automatic redirect(input logic [31:0] tgt, input string tag);
      redirect_valid = 1'b1;
      redirect_pc = tgt;
      step(tag);
      redirect_valid = 1'b0;
   endtask

   initial begin
      m_pc = RESET_PC;
      #3;
      check_state("reset");
      fetch_en = 1'b1;
      inst_ready = 1'b1;
      #4 rst_n = 1'b1;

      // first edge pushes PC 0; nothing visible until after it
      check("pre_first_edge.valid", 32'(inst_valid), 32'h0);
      for (int i = 0; i < 6; i++) step("stream");

      inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) step("backpressure");
      check("bp.count_sat", 32'(count), 32'd2);
      inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) step("release");

      inst_ready = 1'b0;
      for (int i = 0; i < 3; i++) step("fill");
      inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) step("full_pop");

      inst_ready = 1'b0;
      for (int i = 0; i < 3; i++) step("pre_redirect");
      inst_ready = 1'b1;
      redirect(32'h0000_0103, "redirect");
      check("redir.addr", imem_addr, 32'h0000_0100);
      step("post_redir1");
      check("redir.pc100", inst_pc, 32'h0000_0100);
      step("post_redir2");
      check("redir.pc104", inst_pc, 32'h0000_0104);

      mem_xor = 32'h5A5A_C3C3;
      redirect(32'h0000_2000, "b2b_a");
      redirect(32'h0000_3002, "b2b_b");
      for (int i = 0; i < 3; i++) step("b2b_stream");

      fetch_en = 1'b0;
      inst_ready = 1'b0;
      step("fe_off_hold");
      inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) step("fe_off_drain");
      redirect(32'h0000_4444, "fe_off_redirect");
      step("fe_off_idle");
      fetch_en = 1'b1;

      redirect(32'hFFFF_FFF8, "wrap_redirect");
      for (int i = 0; i < 4; i++) step("wrap");

      for (int i = 0; i < 60; i++) begin
         fetch_en = ($urandom_range(0, 3) != 0);
         inst_ready = ($urandom_range(0, 2) != 0);
         redirect_valid = ($urandom_range(0, 9) == 0);
         redirect_pc = $urandom;
         step("random");
      end
      redirect_valid = 1'b0;

      fetch_en = 1'b1;
      inst_ready = 1'b0;
      for (int i = 0; i < 3; i++) step("pre_reset");
      #2 rst_n = 1'b0;
      #1;
      sb.delete();
      m_pc = RESET_PC;
      check_state("async_reset");
      #2 rst_n = 1'b1;
      inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) step("after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
